// File: rtl/morse_sequencer.sv
// Morse blinker for the red status LED: a small character FIFO feeding a mark/space timing FSM.
// Optional MORSE_BUSY_LED_EN lights the blue LED while the sequencer is active.
module morse_sequencer #(
  parameter int unsigned UNIT_CYCLES = 4800000,
  parameter int unsigned CNT_W       = 26,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic [7:0] i_char,
  input  logic       i_char_valid,
  output logic       o_char_ready,
  input  logic       i_enable,
  output logic       o_busy,
  output logic       o_char_done,
  output logic       o_led_r,
  output logic       o_led_g,
  output logic       o_led_b
);

  localparam int unsigned AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CNT_W-1:0] END1 = CNT_W'(UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] END3 = CNT_W'(3 * UNIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] END4 = CNT_W'(4 * UNIT_CYCLES - 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_MARK, S_SPACE, S_CHAR_GAP, S_WORD_GAP} state_t;
  typedef enum logic [1:0] {K_SYM, K_SPACE, K_BAD} kind_t;

  // Character FIFO
  logic [7:0]    mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_n;
  logic          ready_q, push, pop;

  assign push    = i_char_valid & ready_q;
  assign count_n = count + CW'(push) - CW'(pop);

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= i_char;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count   <= '0;
      ready_q <= 1'b1;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count   <= count_n;
      ready_q <= (count_n != CW'(FIFO_DEPTH));
    end
  end

  // Head-of-FIFO decode: length plus left-aligned pattern, 1 = dash
  logic [7:0] up_char;
  kind_t      dec_kind;
  logic [2:0] dec_len;
  logic [4:0] dec_pat;

  always_comb begin
    up_char  = mem[rd_ptr];
    if (up_char >= 8'h61 && up_char <= 8'h7A) up_char = up_char - 8'h20;
    dec_kind = K_SYM;
    dec_len  = 3'd0;
    dec_pat  = 5'b00000;
    case (up_char)
      "A": {dec_len, dec_pat} = {3'd2, 5'b01000};
      "B": {dec_len, dec_pat} = {3'd4, 5'b10000};
      "C": {dec_len, dec_pat} = {3'd4, 5'b10100};
      "D": {dec_len, dec_pat} = {3'd3, 5'b10000};
      "E": {dec_len, dec_pat} = {3'd1, 5'b00000};
      "F": {dec_len, dec_pat} = {3'd4, 5'b00100};
      "G": {dec_len, dec_pat} = {3'd3, 5'b11000};
      "H": {dec_len, dec_pat} = {3'd4, 5'b00000};
      "I": {dec_len, dec_pat} = {3'd2, 5'b00000};
      "J": {dec_len, dec_pat} = {3'd4, 5'b01110};
      "K": {dec_len, dec_pat} = {3'd3, 5'b10100};
      "L": {dec_len, dec_pat} = {3'd4, 5'b01000};
      "M": {dec_len, dec_pat} = {3'd2, 5'b11000};
      "N": {dec_len, dec_pat} = {3'd2, 5'b10000};
      "O": {dec_len, dec_pat} = {3'd3, 5'b11100};
      "P": {dec_len, dec_pat} = {3'd4, 5'b01100};
      "Q": {dec_len, dec_pat} = {3'd4, 5'b11010};
      "R": {dec_len, dec_pat} = {3'd3, 5'b01000};
      "S": {dec_len, dec_pat} = {3'd3, 5'b00000};
      "T": {dec_len, dec_pat} = {3'd1, 5'b10000};
      "U": {dec_len, dec_pat} = {3'd3, 5'b00100};
      "V": {dec_len, dec_pat} = {3'd4, 5'b00010};
      "W": {dec_len, dec_pat} = {3'd3, 5'b01100};
      "X": {dec_len, dec_pat} = {3'd4, 5'b10010};
      "Y": {dec_len, dec_pat} = {3'd4, 5'b10110};
      "Z": {dec_len, dec_pat} = {3'd4, 5'b11000};
      "0": {dec_len, dec_pat} = {3'd5, 5'b11111};
      "1": {dec_len, dec_pat} = {3'd5, 5'b01111};
      "2": {dec_len, dec_pat} = {3'd5, 5'b00111};
      "3": {dec_len, dec_pat} = {3'd5, 5'b00011};
      "4": {dec_len, dec_pat} = {3'd5, 5'b00001};
      "5": {dec_len, dec_pat} = {3'd5, 5'b00000};
      "6": {dec_len, dec_pat} = {3'd5, 5'b10000};
      "7": {dec_len, dec_pat} = {3'd5, 5'b11000};
      "8": {dec_len, dec_pat} = {3'd5, 5'b11100};
      "9": {dec_len, dec_pat} = {3'd5, 5'b11110};
      " ": dec_kind = K_SPACE;
      default: dec_kind = K_BAD;
    endcase
  end

  // Sequencer FSM
  state_t           state, state_n;
  kind_t            kind_q, kind_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [2:0]       len_q, len_n;
  logic [4:0]       pat_q, pat_n;
  logic             done_n;
  logic             led_r_q, busy_q, done_q;

  always_comb begin
    state_n = state;
    kind_n  = kind_q;
    len_n   = len_q;
    pat_n   = pat_q;
    pop     = 1'b0;
    unique case (state)
      S_IDLE: begin
        if ((count != CW'(0)) && i_enable) begin
          state_n = S_LOAD;
          kind_n  = dec_kind;
          len_n   = dec_len;
          pat_n   = dec_pat;
        end
      end
      S_LOAD: begin
        pop = 1'b1;
        case (kind_q)
          K_SYM:   state_n = S_MARK;
          K_SPACE: state_n = S_WORD_GAP;
          default: state_n = S_IDLE;
        endcase
      end
      S_MARK: begin
        if (timer == (pat_q[4] ? END3 : END1)) begin
          if (len_q > 3'd1) begin
            state_n = S_SPACE;
            len_n   = len_q - 3'd1;
            pat_n   = {pat_q[3:0], 1'b0};
          end else begin
            state_n = S_CHAR_GAP;
          end
        end
      end
      S_SPACE:    if (timer == END1) state_n = S_MARK;
      S_CHAR_GAP: if (timer == END3) state_n = S_IDLE;
      S_WORD_GAP: if (timer == END4) state_n = S_IDLE;
      default:    state_n = S_IDLE;
    endcase
    timer_n = ((state_n != state) || (state == S_IDLE)) ? '0 : timer + CNT_W'(1);
    // Outputs are registered from next-state so they line up with the state they describe
    done_n  = ((state_n == S_LOAD) && (kind_n == K_BAD)) ||
              ((state_n == S_CHAR_GAP) && (timer_n == END3)) ||
              ((state_n == S_WORD_GAP) && (timer_n == END4));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state   <= S_IDLE;
      kind_q  <= K_BAD;
      timer   <= '0;
      len_q   <= 3'd0;
      pat_q   <= 5'b00000;
      led_r_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state   <= state_n;
      kind_q  <= kind_n;
      timer   <= timer_n;
      len_q   <= len_n;
      pat_q   <= pat_n;
      led_r_q <= (state_n != S_MARK);
      busy_q  <= (state_n != S_IDLE);
      done_q  <= done_n;
    end
  end

  assign o_char_ready = ready_q;
  assign o_busy       = busy_q;
  assign o_char_done  = done_q;
  assign o_led_r      = led_r_q;
  assign o_led_g      = 1'b1;

`ifdef MORSE_BUSY_LED_EN
  logic led_b_q;
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) led_b_q <= 1'b1;
    else       led_b_q <= (state_n == S_IDLE);
  end
  assign o_led_b = led_b_q;
`else
  assign o_led_b = 1'b1;
`endif

endmodule

// File: tb/tb_morse_sequencer.sv
// Self-checking bench for morse_sequencer (UNIT_CYCLES=4): vector table plus run-length scoreboard.
module tb_morse_sequencer;
  logic       i_clk = 1'b0;
  logic       i_rst;
  logic [7:0] i_char;
  logic       i_char_valid;
  logic       o_char_ready;
  logic       i_enable;
  logic       o_busy, o_char_done, o_led_r, o_led_g, o_led_b;

  always #5 i_clk = ~i_clk;

  morse_sequencer #(.UNIT_CYCLES(4), .CNT_W(8), .FIFO_DEPTH(4)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_char(i_char), .i_char_valid(i_char_valid),
    .o_char_ready(o_char_ready), .i_enable(i_enable), .o_busy(o_busy),
    .o_char_done(o_char_done), .o_led_r(o_led_r), .o_led_g(o_led_g), .o_led_b(o_led_b)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int exp_low[$];
  int exp_high[$];
  bit prev_led;
  bit high_chk, high_skip;
  int low_len, high_len, low_total, done_cnt;

  typedef struct { logic [7:0] ch; int low; } vec_t;
  vec_t vecs[14];

  task automatic check(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, want %0d", name, act, exp);
    end
  endtask

  function automatic string code_of(input logic [7:0] c);
    logic [7:0] u;
    u = (c >= 8'h61 && c <= 8'h7A) ? c - 8'h20 : c;
    case (u)
      "A": return ".-";    "B": return "-...";  "C": return "-.-.";  "D": return "-..";
      "E": return ".";     "F": return "..-.";  "G": return "--.";   "H": return "....";
      "I": return "..";    "J": return ".---";  "K": return "-.-";   "L": return ".-..";
      "M": return "--";    "N": return "-.";    "O": return "---";   "P": return ".--.";
      "Q": return "--.-";  "R": return ".-.";   "S": return "...";   "T": return "-";
      "U": return "..-";   "V": return "...-";  "W": return ".--";   "X": return "-..-";
      "Y": return "-.--";  "Z": return "--..";
      "0": return "-----"; "1": return ".----"; "2": return "..---"; "3": return "...--";
      "4": return "....-"; "5": return "....."; "6": return "-...."; "7": return "--...";
      "8": return "---.."; "9": return "----.";
      default: return "";
    endcase
  endfunction

  task automatic expect_char(input logic [7:0] c);
    string s;
    s = code_of(c);
    for (int i = 0; i < s.len(); i++) exp_low.push_back((s[i] == "-") ? 12 : 4);
  endtask

  // Scoreboard: measures LED run lengths once per cycle, 1 time unit after the edge
  task automatic monitor();
    if (o_led_r == 1'b0) begin
      if (prev_led) begin
        if (high_chk) begin
          if (high_skip) high_skip = 1'b0;
          else if (exp_high.size() == 0) begin
            n_tests++; n_fail++;
            $display("FAIL high_run: unexpected run of %0d cycles, want none", high_len);
          end else check("high_run", high_len, exp_high.pop_front());
        end
        low_len = 0;
      end
      low_len++;
      low_total++;
    end else begin
      if (!prev_led) begin
        if (exp_low.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL low_run: unexpected run of %0d cycles, want none", low_len);
        end else check("low_run", low_len, exp_low.pop_front());
        high_len = 0;
      end
      high_len++;
    end
    prev_led = o_led_r;
    if (o_char_done) done_cnt++;
  endtask

  task automatic sb_clear();
    exp_low.delete();
    exp_high.delete();
    prev_led = 1'b1;
    low_len = 0;
    high_len = 0;
    high_chk = 1'b0;
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
    monitor();
  endtask

  task automatic push_char(input logic [7:0] c);
    int waited = 0;
    while (!o_char_ready && waited < 200) begin tick(); waited++; end
    check("push_ready_wait", int'(o_char_ready), 1);
    i_char = c;
    i_char_valid = 1'b1;
    tick();
    i_char_valid = 1'b0;
    expect_char(c);
  endtask

  task automatic wait_idle(input int budget);
    int quiet = 0;
    for (int i = 0; i < budget && quiet < 4; i++) begin
      tick();
      if (!o_busy) quiet++; else quiet = 0;
    end
    check("idle_wait", (quiet >= 4) ? 1 : 0, 1);
  endtask

  initial begin
    int d0, t0, model_cnt, exp_b;
    logic [7:0] full_chars[5];
    vecs[0]  = '{8'h45, 4};   // E .
    vecs[1]  = '{8'h61, 16};  // a .-
    vecs[2]  = '{8'h51, 40};  // Q --.-
    vecs[3]  = '{8'h30, 60};  // 0 -----
    vecs[4]  = '{8'h35, 20};  // 5 .....
    vecs[5]  = '{8'h7A, 32};  // z --..
    vecs[6]  = '{8'h39, 52};  // 9 ----.
    vecs[7]  = '{8'h52, 20};  // R .-.
    vecs[8]  = '{8'h23, 0};   // #
    vecs[9]  = '{8'h40, 0};   // @ just below A
    vecs[10] = '{8'h5B, 0};   // [ just above Z
    vecs[11] = '{8'h7B, 0};   // { just above z
    vecs[12] = '{8'h2F, 0};   // / just below 0
    vecs[13] = '{8'h3A, 0};   // : just above 9
    full_chars[0] = 8'h44; full_chars[1] = 8'h47; full_chars[2] = 8'h4B;
    full_chars[3] = 8'h55; full_chars[4] = 8'h58;

    sb_clear();
    low_total = 0; done_cnt = 0; high_skip = 1'b0;
    i_rst = 1'b1; i_char = 8'h00; i_char_valid = 1'b0; i_enable = 1'b1;
    tick(); tick();
    check("rst_led_r", int'(o_led_r), 1);
    check("rst_led_g", int'(o_led_g), 1);
    check("rst_led_b", int'(o_led_b), 1);
    check("rst_busy", int'(o_busy), 0);
    check("rst_done", int'(o_char_done), 0);
    check("rst_ready", int'(o_char_ready), 1);
    i_rst = 1'b0;
    tick();

    // Exact timing of a single 'E'
    push_char(8'h45);
    for (int k = 1; k <= 18; k++) begin
      tick();
      check($sformatf("e_led_r_k%0d", k), int'(o_led_r), (k >= 2 && k <= 5) ? 0 : 1);
      check($sformatf("e_done_k%0d", k), int'(o_char_done), (k == 17) ? 1 : 0);
      check($sformatf("e_busy_k%0d", k), int'(o_busy), (k <= 17) ? 1 : 0);
`ifdef MORSE_BUSY_LED_EN
      exp_b = (k <= 17) ? 0 : 1;
`else
      exp_b = 1;
`endif
      check($sformatf("e_led_b_k%0d", k), int'(o_led_b), exp_b);
    end
    wait_idle(50);

    // Vector table
    foreach (vecs[i]) begin
      d0 = done_cnt; t0 = low_total;
      push_char(vecs[i].ch);
      wait_idle(400);
      check($sformatf("vec%0d_low_total", i), low_total - t0, vecs[i].low);
      check($sformatf("vec%0d_done", i), done_cnt - d0, 1);
    end

    // Unsupported then 'T': done in LOAD, LED untouched
    d0 = done_cnt;
    push_char(8'h23);
    tick();
    check("bad_done_load", int'(o_char_done), 1);
    check("bad_led_load", int'(o_led_r), 1);
    check("bad_busy_load", int'(o_busy), 1);
    tick();
    check("bad_done_after", int'(o_char_done), 0);
    check("bad_busy_after", int'(o_busy), 0);
    t0 = low_total;
    push_char(8'h54);
    wait_idle(200);
    check("t_low_total", low_total - t0, 12);
    check("bad_t_done", done_cnt - d0, 2);

    // SOS: mark and gap runs
    d0 = done_cnt;
    high_chk = 1'b1; high_skip = 1'b1;
    exp_high = '{4, 4, 14, 4, 4, 14, 4, 4};
    push_char(8'h53); push_char(8'h4F); push_char(8'h53);
    wait_idle(600);
    check("sos_done", done_cnt - d0, 3);
    check("sos_high_left", exp_high.size(), 0);
    high_chk = 1'b0;

    // A, word gap, A
    d0 = done_cnt;
    high_chk = 1'b1; high_skip = 1'b1;
    exp_high = '{4, 32, 4};
    push_char(8'h41); push_char(8'h20); push_char(8'h41);
    wait_idle(600);
    check("word_done", done_cnt - d0, 3);
    check("word_high_left", exp_high.size(), 0);
    high_chk = 1'b0;

    // FIFO full with sequencer disabled
    i_enable = 1'b0;
    d0 = done_cnt; t0 = low_total; model_cnt = 0;
    for (int i = 0; i < 5; i++) begin
      check($sformatf("full_ready_%0d", i), int'(o_char_ready), (model_cnt < 4) ? 1 : 0);
      i_char = full_chars[i];
      i_char_valid = 1'b1;
      tick();
      if (model_cnt < 4) begin expect_char(full_chars[i]); model_cnt++; end
    end
    i_char_valid = 1'b0;
    check("full_ready_end", int'(o_char_ready), 0);
    for (int i = 0; i < 10; i++) tick();
    check("full_hold_busy", int'(o_busy), 0);
    i_enable = 1'b1;
    wait_idle(1000);
    check("full_done", done_cnt - d0, 4);
    check("full_low_total", low_total - t0, 96);
    check("full_ready_after", int'(o_char_ready), 1);

    // Enable dropped mid-character: current char finishes, FIFO retained
    d0 = done_cnt;
    push_char(8'h41); push_char(8'h45);
    for (int i = 0; i < 10 && o_led_r; i++) tick();
    check("en_mark_started", int'(o_led_r), 0);
    i_enable = 1'b0;
    for (int i = 0; i < 60; i++) tick();
    check("en_hold_busy", int'(o_busy), 0);
    check("en_hold_done", done_cnt - d0, 1);
    i_enable = 1'b1;
    wait_idle(200);
    check("en_resume_done", done_cnt - d0, 2);

    // Async reset in the middle of a dash, with characters queued behind it
    push_char(8'h54);
    for (int i = 0; i < 10 && o_led_r; i++) tick();
    tick(); tick(); tick();
    check("rst_in_dash", int'(o_led_r), 0);
    i_char = 8'h45; i_char_valid = 1'b1;
    tick(); tick();
    i_char_valid = 1'b0;
    #2;
    i_rst = 1'b1;
    #1;
    check("arst_led_r", int'(o_led_r), 1);
    check("arst_busy", int'(o_busy), 0);
    check("arst_done", int'(o_char_done), 0);
    sb_clear();
    t0 = low_total;
    tick(); tick();
    i_rst = 1'b0;
    for (int i = 0; i < 10; i++) tick();
    check("arst_ready", int'(o_char_ready), 1);
    check("arst_fifo_empty", int'(o_busy), 0);
    check("arst_no_marks", low_total - t0, 0);

    check("low_q_left", exp_low.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
